// File: rtl/mmio_debug_bridge.sv
// mmio_debug_bridge
//   UART-byte-driven MMIO initiator. A command stream of
//     'R' (0x52) + addr[4]            -> single MMIO read, reply rdata (4 bytes, LSB first)
//     'W' (0x57) + addr[4] + data[4]  -> single MMIO write, reply 'K'
//   (all multi-byte fields little-endian) is turned into one MMIO request
//   cycle and a byte response. Unknown opcodes reply '?', a read that gets no
//   valid within TIMEOUT cycles replies 'T'.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_valid   received byte + one-cycle strobe
//   tx_data, tx_we      byte to transmitter + one-cycle write strobe
//   tx_ready            transmitter can accept a byte
//   oe, we              MMIO access enable / byte write enables (request cycle only)
//   addr, wdata         MMIO byte address / write data
//   rdata, valid        MMIO read data + response strobe
//   busy                FSM not idle
//   overrun             a received byte was dropped this cycle
module mmio_debug_bridge #(
  parameter int MEM_SCALE = 27,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_ready,
  output logic [3:0]           oe,
  output logic [MEM_SCALE-1:0] addr,
  output logic [31:0]          wdata,
  output logic [3:0]           we,
  input  logic [31:0]          rdata,
  input  logic                 valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_SEND, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   resp_q, resp_d;     // pending response bytes, next one in [7:0]
  logic [2:0]    resp_n_q, resp_n_d; // number of response bytes still to send
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      resp_n_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resp_q   <= resp_d;
      resp_n_q <= resp_n_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = resp_q;
    resp_n_d = resp_n_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h52 || rx_data == 8'h57) begin
            is_wr_d = (rx_data == 8'h57);
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            resp_d   = 32'h0000_003F;
            resp_n_d = 3'd1;
            state_d  = S_SEND;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d[8*cnt_q +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;  // wraps to 0 after the 4th byte, ready for DATA
          if (cnt_q == 2'd3) state_d = is_wr_q ? S_DATA : S_REQ;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d[8*cnt_q +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (is_wr_q) begin
          // Writes are posted: acknowledge immediately, valid is not awaited.
          resp_d   = 32'h0000_004B;
          resp_n_d = 3'd1;
          state_d  = S_SEND;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // valid wins over a timeout landing in the same cycle
        if (valid) begin
          resp_d   = rdata;
          resp_n_d = 3'd4;
          state_d  = S_SEND;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          resp_d   = 32'h0000_0054;
          resp_n_d = 3'd1;
          state_d  = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          resp_d   = resp_q >> 8;
          resp_n_d = resp_n_q - 3'd1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        // One dead cycle guarantees tx_we is never asserted back to back.
        state_d = (resp_n_q != 3'd0) ? S_SEND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset cycle can never emit a pulse.
  assign oe      = (!rst && state_q == S_REQ) ? 4'hF : 4'h0;
  assign we      = (!rst && state_q == S_REQ && is_wr_q) ? 4'hF : 4'h0;
  assign tx_we   = !rst && (state_q == S_SEND) && tx_ready;
  assign tx_data = (state_q == S_SEND) ? resp_q[7:0] : 8'h00;
  assign busy    = (state_q != S_IDLE);
  assign overrun = !rst && rx_valid &&
                   (state_q == S_REQ  || state_q == S_WAIT ||
                    state_q == S_SEND || state_q == S_GAP);
  assign addr    = addr_q[MEM_SCALE-1:0];
  assign wdata   = wdata_q;

  // Address bits above MEM_SCALE are accepted on the wire but never used.
  generate
    if (MEM_SCALE < 32) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_q[31:MEM_SCALE];
    end
  endgenerate

endmodule
